// File: rtl/flow_window_sum.sv
// ---------------------------------------------------------------------------
// flow_window_sum
//   Sliding-window accumulator for the FlowDSL dataflow fabric. It keeps the
//   last DEPTH accepted samples in a register delay line and a running sum
//   that adds the newest sample and drops the oldest. The sum wraps modulo
//   2^WIDTH.
//
// Ports
//   clk        : rising-edge clock
//   reset_n    : synchronous reset, active-low (overrides everything)
//   in_valid   : in0 carries a sample this cycle
//   in0        : sample data (unsigned, WIDTH bits)
//   clear      : synchronous flush of the window state (below reset)
//   out0       : registered window sum (partial sums while filling)
//   out_valid  : one-cycle pulse per accepted sample once the window is full
//   fill_count : samples currently in the window, saturates at DEPTH
// ---------------------------------------------------------------------------
module flow_window_sum #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 6,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in0,
  input  logic             clear,
  output logic [WIDTH-1:0] out0,
  output logic             out_valid,
  output logic [CW-1:0]    fill_count
);

  logic [WIDTH-1:0] dly_p1 [DEPTH];
  logic [WIDTH-1:0] acc_p1;
  logic [CW-1:0]    fill_p1;
  logic             vld_p1;

  // The dropped entry was always added earlier (empty slots hold 0), so a
  // plain wrapping add/subtract keeps the sum exact modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] window_next(
    input logic [WIDTH-1:0] acc,
    input logic [WIDTH-1:0] add,
    input logic [WIDTH-1:0] drop
  );
    return acc + add - drop;
  endfunction

  function automatic logic [CW-1:0] fill_next(input logic [CW-1:0] fill);
    return (fill == CW'(DEPTH)) ? fill : fill + CW'(1);
  endfunction

  // Stage p0 -> p1: accept sample, shift delay line, update sum and fill.
  // The window advances per accepted sample only; bubbles hold all state.
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      for (int k = 0; k < DEPTH; k++) begin
        dly_p1[k] <= '0;
      end
      acc_p1  <= '0;
      fill_p1 <= '0;
      vld_p1  <= 1'b0;
    end else if (in_valid) begin
      dly_p1[0] <= in0;
      for (int k = 1; k < DEPTH; k++) begin
        dly_p1[k] <= dly_p1[k-1];
      end
      acc_p1  <= window_next(acc_p1, in0, dly_p1[DEPTH-1]);
      fill_p1 <= fill_next(fill_p1);
      vld_p1  <= (fill_next(fill_p1) == CW'(DEPTH));
    end else begin
      vld_p1 <= 1'b0;
    end
  end

  assign out0       = acc_p1;
  assign out_valid  = vld_p1;
  assign fill_count = fill_p1;

endmodule

// File: tb/tb_flow_window_sum.sv
// ---------------------------------------------------------------------------
// tb_flow_window_sum
//   Drives a DEPTH=6 and a DEPTH=1 instance with identical stimulus and
//   compares both against a queue-based model of the window: the expected
//   sum is the arithmetic sum of the last DEPTH accepted samples.
// ---------------------------------------------------------------------------
module tb_flow_window_sum;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [31:0] in0;
  logic        clear;

  logic [31:0] out0_a, out0_b;
  logic        ovld_a, ovld_b;
  logic [2:0]  fill_a;
  logic [0:0]  fill_b;

  int passed = 0;
  int total  = 0;

  logic [31:0] win6 [$];
  logic [31:0] win1 [$];
  logic        ev6, ev1;

  always #5 clk = ~clk;

  flow_window_sum #(.WIDTH(32), .DEPTH(6)) dut_a (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in0(in0),
    .clear(clear), .out0(out0_a), .out_valid(ovld_a), .fill_count(fill_a)
  );

  flow_window_sum #(.WIDTH(32), .DEPTH(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in0(in0),
    .clear(clear), .out0(out0_b), .out_valid(ovld_b), .fill_count(fill_b)
  );

  function automatic logic [31:0] qsum(input logic [31:0] q[$]);
    logic [31:0] s = 32'd0;
    foreach (q[i]) s = s + q[i];
    return s;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock: drive inputs, let the edge happen, advance the model,
  // then compare both instances 1 time unit after the edge.
  task automatic cycle(input logic r, input logic c, input logic v,
                       input logic [31:0] d);
    reset_n  = r;
    clear    = c;
    in_valid = v;
    in0      = d;
    @(posedge clk);
    if (!r || c) begin
      win6.delete(); win1.delete();
      ev6 = 1'b0; ev1 = 1'b0;
    end else if (v) begin
      win6.push_front(d);
      if (win6.size() > 6) void'(win6.pop_back());
      ev6 = (win6.size() == 6);
      win1.push_front(d);
      if (win1.size() > 1) void'(win1.pop_back());
      ev1 = (win1.size() == 1);
    end else begin
      ev6 = 1'b0; ev1 = 1'b0;
    end
    #1;
    chk("d6_out0",  64'(out0_a), 64'(qsum(win6)));
    chk("d6_valid", 64'(ovld_a), 64'(ev6));
    chk("d6_fill",  64'(fill_a), 64'(win6.size()));
    chk("d1_out0",  64'(out0_b), 64'(qsum(win1)));
    chk("d1_valid", 64'(ovld_b), 64'(ev1));
    chk("d1_fill",  64'(fill_b), 64'(win1.size()));
  endtask

  initial begin
    reset_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in0 = '0;
    ev6 = 1'b0; ev1 = 1'b0;

    // Reset held with a valid sample present, then first sample
    cycle(0, 0, 1, 5);
    cycle(0, 0, 1, 5);
    chk("rst_out0", 64'(out0_a), 64'd0);
    cycle(1, 0, 1, 5);
    chk("first_out0", 64'(out0_a), 64'd5);

    // Fill and steady state, back to back
    cycle(0, 0, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      cycle(1, 0, 1, 32'(i));
      if (i == 6) chk("full_sum21", 64'(out0_a), 64'd21);
      if (i == 5) chk("not_full_vld", 64'(ovld_a), 64'd0);
    end
    chk("steady_sum33", 64'(out0_a), 64'd33);
    chk("fill_sat", 64'(fill_a), 64'd6);

    // Same sequence with bubbles between samples
    cycle(0, 0, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      cycle(1, 0, 1, 32'(i));
      cycle(1, 0, 0, 32'hDEAD_BEEF);
    end
    chk("bubble_sum33", 64'(out0_a), 64'd33);
    chk("bubble_vld0", 64'(ovld_a), 64'd0);

    // Modulo wrap: large entries leave the window after six samples
    cycle(0, 0, 0, 0);
    cycle(1, 0, 1, 32'hFFFF_FFFF);
    cycle(1, 0, 1, 32'hFFFF_FFFF);
    chk("wrap_fffe", 64'(out0_a), 64'hFFFF_FFFE);
    cycle(1, 0, 1, 32'd2);
    chk("wrap_zero", 64'(out0_a), 64'd0);
    for (int i = 0; i < 6; i++) cycle(1, 0, 1, 32'd0);
    chk("wrap_tail", 64'(out0_a), 64'd0);

    // Clear mid-stream drops the simultaneous sample
    cycle(0, 0, 0, 0);
    for (int i = 1; i <= 7; i++) cycle(1, 0, 1, 32'(i));
    chk("pre_clear27", 64'(out0_a), 64'd27);
    cycle(1, 1, 1, 32'd9);
    chk("clear_fill", 64'(fill_a), 64'd0);
    cycle(1, 0, 1, 32'd4);
    chk("post_clear4", 64'(out0_a), 64'd4);

    // Reset and clear together mid-stream
    for (int i = 0; i < 4; i++) cycle(1, 0, 1, 32'(10 + i));
    cycle(0, 1, 1, 32'd77);
    chk("collide_out0", 64'(out0_a), 64'd0);
    cycle(1, 0, 1, 32'd7);
    cycle(1, 0, 1, 32'd3);
    chk("d1_last3", 64'(out0_b), 64'd3);

    // Randomized traffic with occasional clear and reset
    for (int i = 0; i < 300; i++) begin
      logic [31:0] d;
      d = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
      cycle(($urandom_range(0, 59) != 0), ($urandom_range(0, 24) == 0),
            ($urandom_range(0, 3) != 0), d);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
